// File: rtl/doy_to_date_seq_if.sv
// rtl/doy_to_date_seq_if.sv - request/result bundle for the day-of-year to date converter
interface doy_to_date_seq_if #(
  parameter int DOY_W = 9
);
  logic             start;
  logic [DOY_W-1:0] day_of_year;
  logic             leap;
  logic             busy;
  logic             valid;
  logic             error;
  logic [3:0]       month;
  logic [7:0]       month_seg_hi;
  logic [7:0]       month_seg_lo;
  logic [3:0]       day_tens;
  logic [3:0]       day_ones;

  modport master (
    output start, day_of_year, leap,
    input  busy, valid, error, month, month_seg_hi, month_seg_lo, day_tens, day_ones
  );

  modport slave (
    input  start, day_of_year, leap,
    output busy, valid, error, month, month_seg_hi, month_seg_lo, day_tens, day_ones
  );
endinterface

// File: rtl/doy_to_date_seq.sv
// rtl/doy_to_date_seq.sv - iterative day-of-year to month/day converter with 7-seg month codes
module doy_to_date_seq #(
  parameter int DOY_W          = 9,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  doy_to_date_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WALK  = 3'd2,
    S_SPLIT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // XOR mask turns the native active-low codes into the selected polarity
  localparam logic [7:0]       SEG_POL   = SEG_ACTIVE_LOW ? 8'h00 : 8'hFF;
  localparam logic [7:0]       SEG_BLANK = 8'hFF ^ SEG_POL;
  localparam logic [DOY_W-1:0] DAYS_365  = DOY_W'(365);
  localparam logic [DOY_W-1:0] TEN       = DOY_W'(10);

  state_t           r_state;
  state_t           w_next_state;
  logic [DOY_W-1:0] r_rem;
  logic             r_lp;
  logic [3:0]       r_m;
  logic [3:0]       r_tens;

  logic             r_error;
  logic [3:0]       r_month;
  logic [7:0]       r_seg_hi;
  logic [7:0]       r_seg_lo;
  logic [3:0]       r_day_tens;
  logic [3:0]       r_day_ones;

  logic             w_busy;
  logic             w_valid;
  logic [4:0]       w_mlen;
  logic [DOY_W-1:0] w_mlen_ext;
  logic [DOY_W-1:0] w_limit;
  logic             w_range_err;
  logic             w_rem_gt_len;
  logic             w_rem_ge10;
  logic [3:0]       w_lo_digit;

  // Length of month m; February grows by the leap bit latched at start
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                      month_len = 5'd28 + {4'd0, lp};
      4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
      default:                   month_len = 5'd31;
    endcase
  endfunction

  // Active-low 7-seg code with DP off for a decimal digit
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  assign w_mlen       = month_len(r_m, r_lp);
  assign w_mlen_ext   = {{(DOY_W-5){1'b0}}, w_mlen};
  assign w_limit      = DAYS_365 + {{(DOY_W-1){1'b0}}, r_lp};
  assign w_range_err  = (r_rem == '0) || (r_rem > w_limit);
  assign w_rem_gt_len = r_rem > w_mlen_ext;
  assign w_rem_ge10   = r_rem >= TEN;
  assign w_lo_digit   = (r_m >= 4'd10) ? (r_m - 4'd10) : r_m;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state selection: range check, month walk, then tens split
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next_state = S_CHECK;
      S_CHECK: w_next_state = w_range_err ? S_DONE : S_WALK;
      S_WALK:  if (!w_rem_gt_len) w_next_state = S_SPLIT;
      S_SPLIT: if (!w_rem_ge10) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_valid = (r_state == S_DONE);
  end

  // Working registers: latch request, peel off whole months, then tens of days
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_lp   <= 1'b0;
      r_m    <= 4'd0;
      r_tens <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rem  <= bus.day_of_year;
            r_lp   <= bus.leap;
            r_m    <= 4'd1;
            r_tens <= 4'd0;
          end
        end
        S_WALK: begin
          if (w_rem_gt_len) begin
            r_rem <= r_rem - w_mlen_ext;
            r_m   <= r_m + 4'd1;
          end
        end
        S_SPLIT: begin
          if (w_rem_ge10) begin
            r_rem  <= r_rem - TEN;
            r_tens <= r_tens + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers: written only on the edge entering DONE, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error    <= 1'b0;
      r_month    <= 4'd0;
      r_seg_hi   <= SEG_BLANK;
      r_seg_lo   <= SEG_BLANK;
      r_day_tens <= 4'd0;
      r_day_ones <= 4'd0;
    end else if (r_state == S_CHECK && w_range_err) begin
      r_error    <= 1'b1;
      r_month    <= 4'd0;
      r_seg_hi   <= SEG_BLANK;
      r_seg_lo   <= SEG_BLANK;
      r_day_tens <= 4'd0;
      r_day_ones <= 4'd0;
    end else if (r_state == S_SPLIT && !w_rem_ge10) begin
      r_error    <= 1'b0;
      r_month    <= r_m;
      r_seg_hi   <= (r_m >= 4'd10) ? (seg_code(4'd1) ^ SEG_POL) : SEG_BLANK;
      r_seg_lo   <= seg_code(w_lo_digit) ^ SEG_POL;
      r_day_tens <= r_tens;
      r_day_ones <= r_rem[3:0];
    end
  end

  assign bus.busy         = w_busy;
  assign bus.valid        = w_valid;
  assign bus.error        = r_error;
  assign bus.month        = r_month;
  assign bus.month_seg_hi = r_seg_hi;
  assign bus.month_seg_lo = r_seg_lo;
  assign bus.day_tens     = r_day_tens;
  assign bus.day_ones     = r_day_ones;

endmodule

// File: tb/tb_doy_to_date_seq.sv
// tb/tb_doy_to_date_seq.sv - randomized and directed checks of doy_to_date_seq against a calendar model
module tb_doy_to_date_seq;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  doy_to_date_seq_if #(.DOY_W(DW)) ifc ();

  doy_to_date_seq #(.DOY_W(DW), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int seg_tab[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // expected values of the result registers from the last completion
  int p_month = 0, p_tens = 0, p_ones = 0, p_err = 0, p_hi = 8'hFF, p_lo = 8'hFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Calendar reference: cumulative month ends, then plain divide/modulo for the day digits
  task automatic ref_model(input int doy, input bit lp, output bit err, output int mon,
                           output int dt, output int d1);
    int ml[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int ends[13];
    int dom;
    ml[1] += int'(lp);
    ends[0] = 0;
    for (int i = 0; i < 12; i++) ends[i+1] = ends[i] + ml[i];
    err = (doy < 1) || (doy > ends[12]);
    mon = 0; dt = 0; d1 = 0;
    if (!err) begin
      for (int m = 1; m <= 12; m++) begin
        if (mon == 0 && doy <= ends[m]) begin
          mon = m;
          dom = doy - ends[m-1];
          dt  = dom / 10;
          d1  = dom % 10;
        end
      end
    end
  endtask

  task automatic run_conv(input int doy, input bit lp, input int repulse_doy, input string tag);
    bit err;
    int mon, dt, d1, lat, ehi, elo, edges;
    bit seen, held, busy_ok;
    ref_model(doy, lp, err, mon, dt, d1);
    lat = err ? 2 : 3 + mon + dt;
    ehi = (!err && mon >= 10) ? 8'hF9 : 8'hFF;
    elo = err ? 8'hFF : seg_tab[mon % 10];

    @(posedge clk); #1;
    ifc.start = 1'b1;
    ifc.day_of_year = DW'(doy);
    ifc.leap = lp;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.day_of_year = DW'($urandom);
    ifc.leap = 1'($urandom);

    edges = 0; seen = 0; held = 1; busy_ok = 1;
    while (!seen && edges < 40) begin
      if (ifc.month !== 4'(p_month) || ifc.day_tens !== 4'(p_tens) || ifc.day_ones !== 4'(p_ones) ||
          ifc.error !== 1'(p_err) || ifc.month_seg_hi !== 8'(p_hi) || ifc.month_seg_lo !== 8'(p_lo))
        held = 0;
      if (ifc.busy !== 1'b1) busy_ok = 0;
      if (repulse_doy >= 0 && edges == 2) begin
        ifc.start = 1'b1;
        ifc.day_of_year = DW'(repulse_doy);
      end
      if (edges == 3) ifc.start = 1'b0;
      @(posedge clk); #1;
      edges++;
      if (ifc.valid === 1'b1) seen = 1;
    end

    check($sformatf("%s.latency", tag), edges + 1, lat);
    check($sformatf("%s.hold", tag), held, 1);
    check($sformatf("%s.busy_run", tag), busy_ok, 1);
    check($sformatf("%s.busy_done", tag), ifc.busy, 1);
    check($sformatf("%s.error", tag), ifc.error, err);
    check($sformatf("%s.month", tag), ifc.month, mon);
    check($sformatf("%s.day_tens", tag), ifc.day_tens, dt);
    check($sformatf("%s.day_ones", tag), ifc.day_ones, d1);
    check($sformatf("%s.seg_hi", tag), ifc.month_seg_hi, ehi);
    check($sformatf("%s.seg_lo", tag), ifc.month_seg_lo, elo);
    @(posedge clk); #1;
    check($sformatf("%s.valid_once", tag), ifc.valid, 0);
    check($sformatf("%s.idle_busy", tag), ifc.busy, 0);

    p_month = mon; p_tens = dt; p_ones = d1; p_err = int'(err); p_hi = ehi; p_lo = elo;
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s.busy", tag), ifc.busy, 0);
    check($sformatf("%s.valid", tag), ifc.valid, 0);
    check($sformatf("%s.error", tag), ifc.error, 0);
    check($sformatf("%s.month", tag), ifc.month, 0);
    check($sformatf("%s.day_tens", tag), ifc.day_tens, 0);
    check($sformatf("%s.day_ones", tag), ifc.day_ones, 0);
    check($sformatf("%s.seg_hi", tag), ifc.month_seg_hi, 8'hFF);
    check($sformatf("%s.seg_lo", tag), ifc.month_seg_lo, 8'hFF);
  endtask

  initial begin
    int extra_valid;
    ifc.start = 1'b0;
    ifc.day_of_year = '0;
    ifc.leap = 1'b0;

    #12;
    check_reset_values("reset");
    @(negedge clk); rst_n = 1'b1;

    run_conv(60, 1'b0, -1, "mar1");
    run_conv(60, 1'b1, -1, "feb29");
    run_conv(366, 1'b1, -1, "leap_dec31");
    run_conv(365, 1'b0, -1, "dec31");
    run_conv(366, 1'b0, -1, "err366");
    run_conv(0, 1'b1, -1, "err0");
    run_conv(513, 1'b1, -1, "err_hibit");
    run_conv(32, 1'b0, -1, "feb1");
    run_conv(1, 1'b0, -1, "jan1");

    run_conv(200, 1'b0, 5, "jul19");
    extra_valid = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (ifc.valid === 1'b1) extra_valid++;
    end
    check("jul19.no_queued", extra_valid, 0);

    // asynchronous reset in the middle of a month walk
    @(posedge clk); #1;
    ifc.start = 1'b1; ifc.day_of_year = DW'(365); ifc.leap = 1'b0;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk); rst_n = 1'b1;
    p_month = 0; p_tens = 0; p_ones = 0; p_err = 0; p_hi = 8'hFF; p_lo = 8'hFF;
    run_conv(31, 1'b0, -1, "jan31");

    for (int lp = 0; lp < 2; lp++)
      for (int d = 1; d <= 365 + lp; d++)
        run_conv(d, 1'(lp), -1, $sformatf("sweep_l%0d_d%0d", lp, d));

    for (int i = 0; i < 40; i++) begin
      int d;
      bit l;
      d = int'($urandom_range(0, 520));
      l = 1'($urandom_range(0, 1));
      run_conv(d, l, -1, $sformatf("rand_l%0d_d%0d", l, d));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
